layernorm_scheduler: RTL and testbench

LAYERNORM_SCHEDULER -- requirements
Module: layernorm_scheduler

---
 rtl/layernorm_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_layernorm_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layernorm_scheduler.sv
`default_nettype none
// =============================================================================
// layernorm_scheduler : round-robin job scheduler for a shared layernorm
// datapath (param fetch, token read issue, result write-back).  Rev 1.0
// =============================================================================
module layernorm_scheduler #(
  parameter  int NREQ = 4,
  parameter  int AW   = 10,
  parameter  int CW   = 8,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0][AW-1:0] req_base,
  input  logic [NREQ-1:0][CW-1:0] req_count,
  input  logic [NREQ-1:0][1:0]    req_bank,
  output logic [NREQ-1:0]         req_ready,
  output logic [1:0]              par_sel,
  output logic                    par_load,
  input  logic                    par_ack,
  input  logic                    hold,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  output logic                    ln_valid_in,
  input  logic                    ln_valid_out,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic [NREQ-1:0]         done,
  output logic [OW-1:0]           owner,
  output logic                    busy,
  output logic                    err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PARAM  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CW:0] CNT_ONE = {{CW{1'b0}}, 1'b1};

  logic [2:0]    state_q,  state_d;
  logic [OW-1:0] owner_q,  owner_d;
  logic [OW-1:0] rr_q,     rr_d;
  logic [AW-1:0] base_q,   base_d;
  logic [CW:0]   count_q,  count_d;
  logic [CW:0]   issue_q,  issue_d;
  logic [CW:0]   wcnt_q,   wcnt_d;
  logic [1:0]    bank_q,   bank_d;
  logic [1:0]    cbank_q,  cbank_d;
  logic          cvalid_q, cvalid_d;
  logic          pload_q,  pload_d;
  logic          lvi_q,    lvi_d;
  logic          err_q,    err_d;

  logic          w_gnt_any;
  logic [OW-1:0] w_gnt_idx;
  logic          w_grant;
  logic          w_last_issue;
  logic          w_wr_ok;
  logic          w_last_write;

  // Round-robin search: the lowest offset from rr_q wins, so scan downward.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NREQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = OW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  assign w_grant      = rst_n && (state_q == S_IDLE) && w_gnt_any;
  assign w_last_issue = rd_en && ((issue_q + CNT_ONE) == count_q);
  assign w_wr_ok      = ln_valid_out && (wcnt_q < count_q) &&
                        ((state_q == S_STREAM) || (state_q == S_DRAIN));
  assign w_last_write = w_wr_ok && ((wcnt_q + CNT_ONE) == count_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_grant) begin
          if (req_count[w_gnt_idx] == '0) begin
            state_d = S_DONE;
          end else if (!cvalid_q || (req_bank[w_gnt_idx] != cbank_q)) begin
            state_d = S_PARAM;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_PARAM: begin
        if (par_ack) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_last_write || (wcnt_q == count_q)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job context, bank cache, counters and error tracking
  always_comb begin
    owner_d  = owner_q;
    rr_d     = rr_q;
    base_d   = base_q;
    count_d  = count_q;
    issue_d  = issue_q;
    wcnt_d   = wcnt_q;
    bank_d   = bank_q;
    cbank_d  = cbank_q;
    cvalid_d = cvalid_q;
    if (w_grant) begin
      owner_d = w_gnt_idx;
      rr_d    = OW'((int'(w_gnt_idx) + 1) % NREQ);
      base_d  = req_base[w_gnt_idx];
      count_d = {1'b0, req_count[w_gnt_idx]};
      bank_d  = req_bank[w_gnt_idx];
      issue_d = '0;
      wcnt_d  = '0;
    end
    if (rd_en) begin
      issue_d = issue_q + CNT_ONE;
    end
    if (w_wr_ok) begin
      wcnt_d = wcnt_q + CNT_ONE;
    end
    if ((state_q == S_PARAM) && par_ack) begin
      cvalid_d = 1'b1;
      cbank_d  = bank_q;
    end
    pload_d = (state_q != S_PARAM) && (state_d == S_PARAM);
    lvi_d   = rd_en;
    err_d   = err_q | (ln_valid_out && !w_wr_ok) |
              (par_ack && (state_q != S_PARAM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= '0;
      rr_q     <= '0;
      base_q   <= '0;
      count_q  <= '0;
      issue_q  <= '0;
      wcnt_q   <= '0;
      bank_q   <= '0;
      cbank_q  <= '0;
      cvalid_q <= 1'b0;
      pload_q  <= 1'b0;
      lvi_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      base_q   <= base_d;
      count_q  <= count_d;
      issue_q  <= issue_d;
      wcnt_q   <= wcnt_d;
      bank_q   <= bank_d;
      cbank_q  <= cbank_d;
      cvalid_q <= cvalid_d;
      pload_q  <= pload_d;
      lvi_q    <= lvi_d;
      err_q    <= err_d;
    end
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (w_grant) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
    done = '0;
    for (int k = 0; k < NREQ; k++) begin
      done[k] = (state_q == S_DONE) && (owner_q == OW'(k));
    end
    par_sel     = (state_q == S_PARAM) ? bank_q : cbank_q;
    par_load    = (state_q == S_PARAM) && pload_q;
    rd_en       = (state_q == S_STREAM) && !hold;
    rd_addr     = rd_en ? (base_q + AW'(issue_q)) : '0;
    wr_en       = w_wr_ok;
    wr_addr     = w_wr_ok ? (base_q + AW'(wcnt_q)) : '0;
    ln_valid_in = lvi_q;
    owner       = owner_q;
    busy        = (state_q != S_IDLE);
    err         = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_layernorm_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// tb_layernorm_scheduler : directed checks of grant order, parameter fetch,
// streaming timing, hold, zero-length jobs, stray strobes and reset.
module tb_layernorm_scheduler;
  localparam int NREQ = 4;
  localparam int AW   = 10;
  localparam int CW   = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NREQ-1:0]         req_valid = '0;
  logic [NREQ-1:0][AW-1:0] req_base = '0;
  logic [NREQ-1:0][CW-1:0] req_count = '0;
  logic [NREQ-1:0][1:0]    req_bank = '0;
  logic [NREQ-1:0]         req_ready;
  logic [1:0]              par_sel;
  logic                    par_load;
  logic                    par_ack = 1'b0;
  logic                    hold = 1'b0;
  logic                    rd_en;
  logic [AW-1:0]           rd_addr;
  logic                    ln_valid_in;
  logic                    ln_valid_out;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [NREQ-1:0]         done;
  logic [1:0]              owner;
  logic                    busy;
  logic                    err;

  layernorm_scheduler #(.NREQ(NREQ), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_base(req_base),
    .req_count(req_count), .req_bank(req_bank), .req_ready(req_ready),
    .par_sel(par_sel), .par_load(par_load), .par_ack(par_ack), .hold(hold),
    .rd_en(rd_en), .rd_addr(rd_addr), .ln_valid_in(ln_valid_in),
    .ln_valid_out(ln_valid_out), .wr_en(wr_en), .wr_addr(wr_addr),
    .done(done), .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath stand-in with latency 1; inj forces a stray valid_out.
  logic dp_q;
  logic inj = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_q <= 1'b0;
    else        dp_q <= ln_valid_in;
  end
  assign ln_valid_out = inj | dp_q;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  int rd_cyc[$];
  int wr_cyc[$];
  int gnt_log[$];
  int done_n, done_cyc, parload_n;
  logic [NREQ-1:0] done_val;
  logic [NREQ-1:0] last_ready = '0;
  logic last_parload = 1'b0;
  logic auto_ack = 1'b0;
  int hold_start = -100;
  int hold_len = 0;

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); rd_cyc.delete(); wr_cyc.delete();
    gnt_log.delete();
    done_n = 0; done_cyc = -1; parload_n = 0; done_val = '0;
  endtask

  task automatic observe();
    #1;
    if (rd_en) begin rd_log.push_back(rd_addr); rd_cyc.push_back(cyc); end
    if (wr_en) begin wr_log.push_back(wr_addr); wr_cyc.push_back(cyc); end
    if (done != '0) begin done_n++; done_cyc = cyc; done_val = done; end
    if (par_load) parload_n++;
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) gnt_log.push_back(k);
    last_ready = req_ready;
    last_parload = par_load;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk); #1; cyc++;
      req_valid = req_valid & ~last_ready;
      par_ack = auto_ack & last_parload;
      hold = (cyc >= hold_start) && (cyc < hold_start + hold_len);
      inj = 1'b0;
      observe();
    end
  endtask

  task automatic start_job(input logic [NREQ-1:0] mask);
    @(posedge clk); #1; cyc++;
    req_valid = mask; par_ack = 1'b0; hold = 1'b0; inj = 1'b0;
    observe();
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] b,
                         input logic [CW-1:0] c, input logic [1:0] bk);
    req_base[idx] = b; req_count[idx] = c; req_bank[idx] = bk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; par_ack = 1'b0; hold = 1'b0; inj = 1'b0;
    auto_ack = 1'b0; hold_start = -100; hold_len = 0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    last_ready = '0; last_parload = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if ({par_load, rd_en, ln_valid_in, wr_en, busy, err} !== 6'b0) begin failures++; $display("FAIL reset_strobes: got %b want 000000", {par_load, rd_en, ln_valid_in, wr_en, busy, err}); end
    checks++; if ({rd_addr, wr_addr, owner, par_sel, done} !== '0) begin failures++; $display("FAIL reset_values: rd=%h wr=%h own=%0d sel=%0d done=%b want all 0", rd_addr, wr_addr, owner, par_sel, done); end
    do_reset();
  endtask

  task automatic test_param_wrap();
    logic [AW-1:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    clear_logs();
    set_req(0, 10'h3FE, 8'd4, 2'd2);
    auto_ack = 1'b1;
    start_job(4'b0001);
    checks++; if (last_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant: got %b want 0001", last_ready); end
    run(1);
    checks++; if (par_load !== 1'b1 || par_sel !== 2'd2 || busy !== 1'b1) begin failures++; $display("FAIL wrap_param: load=%b sel=%0d busy=%b want 1,2,1", par_load, par_sel, busy); end
    run(14);
    checks++; if (parload_n !== 1) begin failures++; $display("FAIL wrap_parload_n: got %0d want 1", parload_n); end
    checks++; if (rd_log.size() != 4 || wr_log.size() != 4) begin failures++; $display("FAIL wrap_counts: rd=%0d wr=%0d want 4,4", rd_log.size(), wr_log.size()); end
    for (int i = 0; i < 4 && i < rd_log.size() && i < wr_log.size(); i++) begin
      checks++; if (rd_log[i] !== exp_a[i] || wr_log[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d]: rd=%h wr=%h want %h", i, rd_log[i], wr_log[i], exp_a[i]); end
    end
    checks++; if (done_n !== 1 || done_val !== 4'b0001) begin failures++; $display("FAIL wrap_done: n=%0d val=%b want 1,0001", done_n, done_val); end
    checks++; if (par_sel !== 2'd2 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL wrap_idle: sel=%0d busy=%b err=%b want 2,0,0", par_sel, busy, err); end
  endtask

  task automatic test_cache_hit_timing();
    int t;
    clear_logs();
    set_req(2, 10'h010, 8'd3, 2'd2);
    start_job(4'b0100);
    t = cyc;
    checks++; if (last_ready !== 4'b0100) begin failures++; $display("FAIL hit_grant: got %b want 0100", last_ready); end
    run(8);
    checks++; if (parload_n !== 0) begin failures++; $display("FAIL hit_parload: got %0d want 0", parload_n); end
    checks++; if (rd_cyc.size() != 3 || wr_cyc.size() != 3) begin failures++; $display("FAIL hit_counts: rd=%0d wr=%0d want 3,3", rd_cyc.size(), wr_cyc.size()); end
    for (int i = 0; i < 3 && i < rd_cyc.size() && i < wr_cyc.size(); i++) begin
      checks++; if (rd_cyc[i] !== t + 1 + i || wr_cyc[i] !== t + 3 + i || rd_log[i] !== AW'(10'h010 + i) || wr_log[i] !== AW'(10'h010 + i)) begin
        failures++; $display("FAIL hit_beat[%0d]: rd@%0d %h wr@%0d %h want rd@%0d wr@%0d addr %h", i, rd_cyc[i] - t, rd_log[i], wr_cyc[i] - t, wr_log[i], 1 + i, 3 + i, 10'h010 + i);
      end
    end
    checks++; if (done_cyc !== t + 6 || done_val !== 4'b0100) begin failures++; $display("FAIL hit_done: at t+%0d val=%b want t+6,0100", done_cyc - t, done_val); end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, AW'(k * 32), 8'd1, 2'd1);
    auto_ack = 1'b1;
    start_job(4'b1111);
    run(40);
    start_job(4'b0001);
    run(10);
    checks++; if (gnt_log.size() != 5) begin failures++; $display("FAIL rr_grants: got %0d want 5", gnt_log.size()); end
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) begin
      checks++; if (gnt_log[i] !== exp_g[i]) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gnt_log[i], exp_g[i]); end
    end
    checks++; if (done_n !== 5 || parload_n !== 1 || wr_log.size() != 5) begin failures++; $display("FAIL rr_jobs: done=%0d load=%0d wr=%0d want 5,1,5", done_n, parload_n, wr_log.size()); end
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      checks++; if (wr_log[i] !== AW'(exp_g[i] * 32)) begin failures++; $display("FAIL rr_wr[%0d]: got %h want %h", i, wr_log[i], exp_g[i] * 32); end
    end
  endtask

  task automatic test_hold();
    int t;
    int exp_r [5];
    clear_logs();
    set_req(1, 10'h100, 8'd5, 2'd1);
    start_job(4'b0010);
    t = cyc;
    exp_r = '{t + 1, t + 2, t + 5, t + 6, t + 7};
    checks++; if (last_ready !== 4'b0010) begin failures++; $display("FAIL hold_grant: got %b want 0010", last_ready); end
    hold_start = t + 3; hold_len = 2;
    run(14);
    hold_start = -100; hold_len = 0;
    checks++; if (rd_log.size() != 5 || wr_log.size() != 5) begin failures++; $display("FAIL hold_counts: rd=%0d wr=%0d want 5,5", rd_log.size(), wr_log.size()); end
    for (int i = 0; i < 5 && i < rd_log.size() && i < wr_log.size(); i++) begin
      checks++; if (rd_cyc[i] !== exp_r[i] || rd_log[i] !== AW'(10'h100 + i) || wr_log[i] !== AW'(10'h100 + i)) begin
        failures++; $display("FAIL hold_beat[%0d]: rd@t+%0d %h wr %h want rd@t+%0d addr %h", i, rd_cyc[i] - t, rd_log[i], wr_log[i], exp_r[i] - t, 10'h100 + i);
      end
    end
    checks++; if (done_cyc !== t + 10 || done_val !== 4'b0010) begin failures++; $display("FAIL hold_done: at t+%0d val=%b want t+10,0010", done_cyc - t, done_val); end
  endtask

  task automatic test_zero_count();
    int t;
    clear_logs();
    set_req(3, 10'h050, 8'd0, 2'd1);
    start_job(4'b1000);
    t = cyc;
    checks++; if (last_ready !== 4'b1000) begin failures++; $display("FAIL zero_grant: got %b want 1000", last_ready); end
    run(4);
    checks++; if (done_cyc !== t + 1 || done_val !== 4'b1000 || done_n !== 1) begin failures++; $display("FAIL zero_done: at t+%0d val=%b n=%0d want t+1,1000,1", done_cyc - t, done_val, done_n); end
    checks++; if (rd_log.size() != 0 || wr_log.size() != 0 || parload_n !== 0) begin failures++; $display("FAIL zero_strobes: rd=%0d wr=%0d load=%0d want 0,0,0", rd_log.size(), wr_log.size(), parload_n); end
  endtask

  task automatic test_stray_valid();
    clear_logs();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL stray_pre_err: got %b want 0", err); end
    @(posedge clk); #1; cyc++;
    inj = 1'b1;
    observe();
    checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stray_wr: wr_en=%b busy=%b want 0,0", wr_en, busy); end
    run(1);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL stray_err: got %b want 1", err); end
    run(5);
    checks++; if (err !== 1'b1 || wr_log.size() != 0) begin failures++; $display("FAIL stray_sticky: err=%b wr=%0d want 1,0", err, wr_log.size()); end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL stray_clear: got %b want 0", err); end
  endtask

  task automatic test_stray_ack();
    @(posedge clk); #1; cyc++;
    par_ack = 1'b1;
    observe();
    run(1);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ack_err: err=%b busy=%b want 1,0", err, busy); end
    do_reset();
  endtask

  task automatic test_reset_mid_job();
    clear_logs();
    set_req(3, 10'h200, 8'd6, 2'd1);
    auto_ack = 1'b1;
    start_job(4'b1000);
    run(4);
    checks++; if (rd_en !== 1'b1 || owner !== 2'd3 || par_sel !== 2'd1) begin failures++; $display("FAIL mid_pre: rd_en=%b owner=%0d sel=%0d want 1,3,1", rd_en, owner, par_sel); end
    rst_n = 1'b0;
    #1;
    checks++; if ({rd_en, ln_valid_in, wr_en, busy, err, par_load} !== 6'b0 || req_ready !== '0 || done !== '0) begin failures++; $display("FAIL mid_strobes: %b ready=%b done=%b want 0", {rd_en, ln_valid_in, wr_en, busy, err, par_load}, req_ready, done); end
    checks++; if (owner !== 2'd0 || par_sel !== 2'd0 || rd_addr !== '0 || wr_addr !== '0) begin failures++; $display("FAIL mid_values: owner=%0d sel=%0d rd=%h wr=%h want 0", owner, par_sel, rd_addr, wr_addr); end
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    last_ready = '0; last_parload = 1'b0;
    clear_logs();
    run(8);
    checks++; if (done_n !== 0 || wr_log.size() != 0 || rd_log.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL mid_abandon: done=%0d wr=%0d rd=%0d busy=%b want 0", done_n, wr_log.size(), rd_log.size(), busy); end
    set_req(3, 10'h200, 8'd2, 2'd0);
    start_job(4'b1000);
    run(12);
    checks++; if (parload_n !== 1 || done_n !== 1 || done_val !== 4'b1000 || wr_log.size() != 2) begin failures++; $display("FAIL mid_after: load=%0d done=%0d val=%b wr=%0d want 1,1,1000,2", parload_n, done_n, done_val, wr_log.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    test_reset();
    test_param_wrap();
    test_cache_hit_timing();
    test_round_robin();
    test_hold();
    test_zero_count();
    test_stray_valid();
    test_stray_ack();
    test_reset_mid_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
